demux1to2: RTL and testbench
============================

Name: demux1to2

Overview:
- Packet-atomic 1-to-2 distributor for the packet-parser datapath; the inverse of the 2-to-1 round-robin merge.
- Accepts one stream of 4-segment NoC flits into a local FIFO.
- Reads a destination bit from each packet's SOP flit and steers the whole packet, SOP through EOP, to output port 1 or port 2 without interleaving.
- Sits between the NoC ingress and two parallel parser lanes.

Parameters:
- NOC_WIDTH, 600, flit width; must be a multiple of 4. Segment width SW = NOC_WIDTH/4.
- FIFO_DEPTH, 32, input FIFO depth in flits; power of 2, at least 4.
- ERR_W, 16, width of the malformed-flit drop counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_data_in  in  NOC_WIDTH  input flit
- i_valid_in  in  1  input flit valid
- i_ready_out  out  1  input credit: high while FIFO free slots > 2
- o_data1_out  out  NOC_WIDTH  port 1 flit
- o_valid1_out  out  1  port 1 valid
- o_ready1_in  in  1  port 1 ready (ready latency 1)
- o_data2_out  out  NOC_WIDTH  port 2 flit
- o_valid2_out  out  1  port 2 valid
- o_ready2_in  in  1  port 2 ready (ready latency 1)
- o_err_count  out  ERR_W  saturating count of dropped flits

Behaviour:
- Reset is asynchronous and active-high; there is one clock.
- Flit format:
  - Segment i occupies bits [(i+1)*SW-1 : i*SW].
  - Segment MSB = valid, MSB-1 = sop, MSB-2 = eop.
  - SOP is always in segment 3 (bit NOC_WIDTH-2).
  - Destination bit is NOC_WIDTH-4, sampled only on the SOP flit: 0 = port 1, 1 = port 2.
  - A flit is an EOP flit if any segment has valid and eop both set.
- Input side:
  - Every cycle with i_valid_in=1 writes one flit; there is no per-flit handshake.
  - Upstream must stop within 1 cycle of i_ready_out falling. The 2-slot margin absorbs this.
  - A write while the FIFO is full is dropped and increments o_err_count. This is a protocol violation.
- FIFO:
  - Show-ahead: a flit written at edge t is at the head during cycle t+1.
  - Minimum accept-to-output latency is 1 cycle.
- Output side:
  - o_readyN_in is registered internally as readyN_r.
  - The block may assert o_validN_out in cycle t only if readyN_r=1, i.e. o_readyN_in was 1 in cycle t-1.
  - Data and valid are combinational from the FIFO head and state.
  - The non-selected port always shows o_valid=0 and o_data=0.
- State machine (fsm_r):
  - IDLE, head present:
    - Head not SOP: pop and discard it, o_err_count++ (saturates at all-ones), stay IDLE.
    - Head SOP, dest=d, readyd_r=1: emit on port d and pop. Go to SEND_d, or stay IDLE if the flit is also EOP (single-flit packet).
    - Head SOP, dest=d, readyd_r=0: hold the head; do not emit.
  - SEND_1 / SEND_2, head present and ready_r of the locked port = 1: emit and pop. On EOP go to IDLE.
  - A SOP flit arriving while in SEND_x is forwarded as data; there is no re-steer.
  - FIFO empty in any state: no emit, hold state.
- Blocking:
  - Head-of-line blocking is intentional. A stalled port blocks packets destined for the other port.
  - Back-to-back packets can be emitted on consecutive cycles, including a direction switch from IDLE.
- Reset:
  - Any cycle with reset=1: FIFO empty, fsm_r=IDLE, readyN_r=0, o_err_count=0, all o_valid=0, all o_data=0.
  - i_ready_out=0 while reset is asserted; it equals 1 from the first cycle after deassertion.
  - Reset mid-packet truncates the packet; downstream receives no EOP, and re-sync relies on the downstream SOP.
- Widths:
  - Used-word count is $clog2(FIFO_DEPTH)+1 bits so the full state is representable.
  - i_ready_out = (FIFO_DEPTH - used) > 2.

Test Plan:
- 3-flit packet, dest bit 596=0, o_ready1_in=1 held → flits appear on port 1 in cycles 1, 2, 3 after the first write; port 2 valid never 1; returns to IDLE.
- Single-flit packets alternating dest 0/1/0/1 with both readies high → 4 consecutive cycles of output, alternating port 1/2, in order; err_count=0.
- 5-flit packet to port 2 with o_ready2_in low for 3 cycles mid-packet → port 2 valid drops exactly one cycle after ready falls and resumes one cycle after ready rises; no flit lost or duplicated; port 1 idle.
- Packet to port 1 (ready low) followed by packet to port 2 (ready high) → nothing emitted on port 2 until the port 1 packet completes (head-of-line blocking).
- Non-SOP flit at head in IDLE, then a valid SOP packet → stray flit discarded, o_err_count=1, packet delivered intact.
- Continuous writes with both readies low → i_ready_out falls when used=30; reset asserted mid-packet → all outputs 0 immediately, o_err_count=0, i_ready_out=1 one cycle after deassert.

Source files
------------

// File: rtl/demux1to2.sv
// rtl/demux1to2.sv - packet-atomic 1-to-2 flit distributor behind a show-ahead input FIFO
// Steers each SOP..EOP packet whole to port 1 or 2 from the SOP destination bit.
module demux1to2 #(
  parameter int NOC_WIDTH  = 600,
  parameter int FIFO_DEPTH = 32,
  parameter int ERR_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NOC_WIDTH-1:0] i_data_in,
  input  logic                 i_valid_in,
  output logic                 i_ready_out,
  output logic [NOC_WIDTH-1:0] o_data1_out,
  output logic                 o_valid1_out,
  input  logic                 o_ready1_in,
  output logic [NOC_WIDTH-1:0] o_data2_out,
  output logic                 o_valid2_out,
  input  logic                 o_ready2_in,
  output logic [ERR_W-1:0]     o_err_count
);

  localparam int SW = NOC_WIDTH / 4;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] MARGIN_C = (AW+1)'(2);
  localparam logic [AW:0] ONE_C    = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_1 = 2'd1,
    SEND_2 = 2'd2
  } state_e;

  logic [NOC_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          used_q, used_d;
  state_e               state_q, state_d;
  logic                 rdy1_q, rdy2_q;
  logic [ERR_W-1:0]     err_q, err_d;

  logic                 empty, full, push, drop, pop, discard, emit1, emit2;
  logic [NOC_WIDTH-1:0] head;
  logic                 head_sop, head_dest, head_eop;
  logic [1:0]           err_inc;
  logic [ERR_W:0]       err_sum;

  assign empty = (used_q == '0);
  assign full  = (used_q == DEPTH_C);
  assign push  = i_valid_in & ~full;
  assign drop  = i_valid_in & full;

  assign head      = mem_q[rd_ptr_q];
  assign head_sop  = head[NOC_WIDTH-2];
  assign head_dest = head[NOC_WIDTH-4];

  always_comb begin
    head_eop = 1'b0;
    for (int s = 0; s < 4; s++) begin
      head_eop = head_eop | (head[(s+1)*SW-1] & head[(s+1)*SW-3]);
    end
  end

  // Credit stays low through reset; the 2-slot margin covers the upstream stop latency.
  assign i_ready_out = ~reset & ((DEPTH_C - used_q) > MARGIN_C);

  always_comb begin
    state_d = state_q;
    emit1   = 1'b0;
    emit2   = 1'b0;
    discard = 1'b0;
    if (!empty) begin
      case (state_q)
        IDLE: begin
          if (!head_sop) begin
            discard = 1'b1;
          end else if (!head_dest) begin
            if (rdy1_q) begin
              emit1 = 1'b1;
              if (!head_eop) state_d = SEND_1;
            end
          end else begin
            if (rdy2_q) begin
              emit2 = 1'b1;
              if (!head_eop) state_d = SEND_2;
            end
          end
        end
        SEND_1: begin
          if (rdy1_q) begin
            emit1 = 1'b1;
            if (head_eop) state_d = IDLE;
          end
        end
        SEND_2: begin
          if (rdy2_q) begin
            emit2 = 1'b1;
            if (head_eop) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pop = emit1 | emit2 | discard;

  assign o_valid1_out = emit1;
  assign o_valid2_out = emit2;
  assign o_data1_out  = emit1 ? head : '0;
  assign o_data2_out  = emit2 ? head : '0;
  assign o_err_count  = err_q;

  always_comb begin
    used_d = used_q;
    case ({push, pop})
      2'b10:   used_d = used_q + ONE_C;
      2'b01:   used_d = used_q - ONE_C;
      default: used_d = used_q;
    endcase
  end

  // A full-FIFO write and a stray-head discard can coincide, so the counter may step by 2.
  assign err_inc = {1'b0, drop} + {1'b0, discard};
  assign err_sum = {1'b0, err_q} + {{(ERR_W-1){1'b0}}, err_inc};
  assign err_d   = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      state_q  <= IDLE;
      rdy1_q   <= 1'b0;
      rdy2_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      used_q  <= used_d;
      state_q <= state_d;
      rdy1_q  <= o_ready1_in;
      rdy2_q  <= o_ready2_in;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_demux1to2.sv
// tb/tb_demux1to2.sv - self-checking bench for demux1to2
// Packet-level reference model checked every cycle, plus directed literal expectations.
module tb_demux1to2;

  localparam int NW = 600;
  localparam int SW = NW / 4;
  localparam int DEPTH = 32;

  logic          clk;
  logic          reset;
  logic [NW-1:0] i_data_in;
  logic          i_valid_in;
  logic          i_ready_out;
  logic [NW-1:0] o_data1_out;
  logic          o_valid1_out;
  logic          o_ready1_in;
  logic [NW-1:0] o_data2_out;
  logic          o_valid2_out;
  logic          o_ready2_in;
  logic [15:0]   o_err_count;

  demux1to2 #(.NOC_WIDTH(NW), .FIFO_DEPTH(DEPTH), .ERR_W(16)) dut (
    .clk(clk), .reset(reset),
    .i_data_in(i_data_in), .i_valid_in(i_valid_in), .i_ready_out(i_ready_out),
    .o_data1_out(o_data1_out), .o_valid1_out(o_valid1_out), .o_ready1_in(o_ready1_in),
    .o_data2_out(o_data2_out), .o_valid2_out(o_valid2_out), .o_ready2_in(o_ready2_in),
    .o_err_count(o_err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_int(input string name, input integer act, input integer exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_bus(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [NW-1:0] mk(input bit sop, input int eseg, input bit dest, input logic [15:0] tag);
    logic [NW-1:0] f;
    f = '0;
    for (int s = 0; s < 4; s++) f[(s+1)*SW-1] = 1'b1;
    f[NW-2] = sop;
    f[NW-4] = dest;
    if (eseg >= 0) f[(eseg+1)*SW-3] = 1'b1;
    f[15:0] = tag;
    return f;
  endfunction

  function automatic bit is_eop(input logic [NW-1:0] f);
    for (int s = 0; s < 4; s++)
      if (f[(s+1)*SW-1] && f[(s+1)*SW-3]) return 1'b1;
    return 1'b0;
  endfunction

  typedef struct {
    int            port;
    int            cyc;
    logic [NW-1:0] data;
  } ev_t;
  ev_t elog[$];

  // Reference model: FIFO as a queue, a packet lock (0 = none) and last-cycle readies.
  logic [NW-1:0] mq[$];
  int            m_lock;
  bit            m_rdy1, m_rdy2;
  integer        m_err;

  initial begin
    m_lock = 0; m_rdy1 = 0; m_rdy2 = 0; m_err = 0;
  end

  always @(negedge clk) begin
    logic [NW-1:0] h, e_d1, e_d2;
    bit e_v1, e_v2, e_rdy, disc, emit;
    int port;
    if (reset) begin
      mq.delete();
      m_lock = 0; m_rdy1 = 0; m_rdy2 = 0; m_err = 0;
    end
    e_v1 = 0; e_v2 = 0; e_d1 = '0; e_d2 = '0; disc = 0; emit = 0; port = 0; h = '0;
    if (!reset && mq.size() > 0) begin
      h = mq[0];
      if (m_lock == 0) begin
        if (!h[NW-2]) disc = 1;
        else port = h[NW-4] ? 2 : 1;
      end else begin
        port = m_lock;
      end
      if (port == 1 && m_rdy1) begin e_v1 = 1; e_d1 = h; emit = 1; end
      if (port == 2 && m_rdy2) begin e_v2 = 1; e_d2 = h; emit = 1; end
    end
    e_rdy = !reset && ((DEPTH - mq.size()) > 2);

    chk_int("valid1", {31'b0, o_valid1_out}, {31'b0, e_v1});
    chk_int("valid2", {31'b0, o_valid2_out}, {31'b0, e_v2});
    chk_bus("data1", o_data1_out, e_d1);
    chk_bus("data2", o_data2_out, e_d2);
    chk_int("ready_out", {31'b0, i_ready_out}, {31'b0, e_rdy});
    chk_int("err_count", {16'b0, o_err_count}, m_err);

    if (o_valid1_out) elog.push_back('{port: 1, cyc: cyc, data: o_data1_out});
    if (o_valid2_out) elog.push_back('{port: 2, cyc: cyc, data: o_data2_out});

    if (!reset) begin
      bit do_push;
      do_push = 0;
      if (i_valid_in) begin
        if (mq.size() == DEPTH) begin
          if (m_err < 65535) m_err = m_err + 1;
        end else begin
          do_push = 1;
        end
      end
      if (disc) begin
        void'(mq.pop_front());
        if (m_err < 65535) m_err = m_err + 1;
      end
      if (emit) begin
        if (is_eop(h)) m_lock = 0;
        else if (m_lock == 0) m_lock = port;
        void'(mq.pop_front());
      end
      if (do_push) mq.push_back(i_data_in);
      m_rdy1 = o_ready1_in;
      m_rdy2 = o_ready2_in;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_valid_in = 1'b0;
    i_data_in  = '0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk_ev(input string name, input int idx, input int port, input int c, input int tag);
    if (idx < elog.size()) begin
      chk_int({name, "_port"}, elog[idx].port, port);
      chk_int({name, "_cyc"}, elog[idx].cyc, c);
      chk_int({name, "_tag"}, {16'b0, elog[idx].data[15:0]}, tag);
    end else begin
      chk_int({name, "_present"}, 0, 1);
    end
  endtask

  initial begin
    int w;
    bit sop, dst;
    int es;
    reset = 1'b1; i_valid_in = 1'b0; i_data_in = '0;
    o_ready1_in = 1'b0; o_ready2_in = 1'b0;
    tick(); tick();
    chk_int("rst_ready_out", {31'b0, i_ready_out}, 0);
    chk_int("rst_err", {16'b0, o_err_count}, 0);
    reset = 1'b0;
    #1;
    chk_int("post_rst_ready_out", {31'b0, i_ready_out}, 1);

    // 3-flit packet to port 1
    o_ready1_in = 1'b1; tick();
    elog.delete();
    w = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      i_valid_in = 1'b1;
      i_data_in  = mk(k == 0, (k == 2) ? 0 : -1, 1'b0, 16'(k));
      tick();
    end
    idle(5);
    chk_int("t1_count", elog.size(), 3);
    for (int k = 0; k < 3; k++) chk_ev("t1", k, 1, w + k, k);

    // alternating single-flit packets
    o_ready2_in = 1'b1; tick();
    elog.delete();
    w = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      i_valid_in = 1'b1;
      i_data_in  = mk(1'b1, (k % 2 == 0) ? 3 : 1, k[0], 16'(16 + k));
      tick();
    end
    idle(5);
    chk_int("t2_count", elog.size(), 4);
    for (int k = 0; k < 4; k++) chk_ev("t2", k, (k % 2 == 0) ? 1 : 2, w + k, 16 + k);
    chk_int("t2_err", {16'b0, o_err_count}, 0);

    // 5-flit packet to port 2 with a 3-cycle stall
    elog.delete();
    w = cyc + 1;
    for (int c = 0; c < 12; c++) begin
      i_valid_in  = (c < 5);
      i_data_in   = (c < 5) ? mk(c == 0, (c == 4) ? 0 : -1, 1'b1, 16'(32 + c)) : '0;
      o_ready2_in = !(c >= 2 && c <= 4);
      tick();
    end
    idle(2);
    chk_int("t3_count", elog.size(), 5);
    chk_ev("t3_0", 0, 2, w + 0, 32);
    chk_ev("t3_1", 1, 2, w + 1, 33);
    chk_ev("t3_2", 2, 2, w + 5, 34);
    chk_ev("t3_3", 3, 2, w + 6, 35);
    chk_ev("t3_4", 4, 2, w + 7, 36);

    // head-of-line blocking
    o_ready1_in = 1'b0; tick();
    elog.delete();
    w = cyc + 1;
    for (int c = 0; c < 10; c++) begin
      i_valid_in = (c < 3);
      case (c)
        0:       i_data_in = mk(1'b1, -1, 1'b0, 16'd48);
        1:       i_data_in = mk(1'b0, 2, 1'b0, 16'd49);
        2:       i_data_in = mk(1'b1, 0, 1'b1, 16'd50);
        default: i_data_in = '0;
      endcase
      o_ready1_in = (c >= 5);
      tick();
    end
    idle(2);
    chk_int("t4_count", elog.size(), 3);
    chk_ev("t4_0", 0, 1, w + 5, 48);
    chk_ev("t4_1", 1, 1, w + 6, 49);
    chk_ev("t4_2", 2, 2, w + 7, 50);

    // stray non-SOP head, then a good packet
    elog.delete();
    w = cyc + 1;
    for (int c = 0; c < 3; c++) begin
      i_valid_in = 1'b1;
      sop = (c == 1);
      dst = 1'b0;
      es  = (c == 2) ? 0 : -1;
      i_data_in = mk(sop, es, dst, 16'(64 + c));
      tick();
    end
    idle(4);
    chk_int("t5_err", {16'b0, o_err_count}, 1);
    chk_int("t5_count", elog.size(), 2);
    chk_ev("t5_0", 0, 1, w + 1, 65);
    chk_ev("t5_1", 1, 1, w + 2, 66);

    // fill with both readies low, overflow once, then reset mid-packet
    o_ready1_in = 1'b0; o_ready2_in = 1'b0; tick();
    elog.delete();
    for (int n = 0; n < 33; n++) begin
      i_valid_in = 1'b1;
      i_data_in  = mk(n == 0, -1, 1'b0, 16'(128 + n));
      tick();
      if (n == 28) chk_int("t6_ready_used29", {31'b0, i_ready_out}, 1);
      if (n == 29) chk_int("t6_ready_used30", {31'b0, i_ready_out}, 0);
    end
    idle(1);
    chk_int("t6_err_overflow", {16'b0, o_err_count}, 2);
    o_ready1_in = 1'b1;
    tick(); tick();
    chk_int("t6_sent_before_rst", elog.size(), 1);
    reset = 1'b1;
    #1;
    chk_int("t6_rst_valid1", {31'b0, o_valid1_out}, 0);
    chk_bus("t6_rst_data1", o_data1_out, '0);
    chk_int("t6_rst_err", {16'b0, o_err_count}, 0);
    chk_int("t6_rst_ready_out", {31'b0, i_ready_out}, 0);
    tick();
    reset = 1'b0;
    #1;
    chk_int("t6_ready_after_rst", {31'b0, i_ready_out}, 1);
    idle(4);
    chk_int("t6_ready_later", {31'b0, i_ready_out}, 1);
    chk_int("t6_no_emit_after_rst", elog.size(), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
